// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencing controller.
package alarm_pkg;

  localparam int HH_W = 5;
  localparam int MM_W = 6;
  localparam int SS_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/alarm_ctrl_tick_gen.sv
// Prescaler producing registered 1 Hz and 2 Hz clock enables from the board clock.
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic sec_tick,
  output logic half_tick
);

  localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2 - 1);

  logic [CW-1:0] count;

  // Free-running 0..CLK_HZ-1 counter; the enables are registered decodes of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      sec_tick  <= 1'b0;
      half_tick <= 1'b0;
    end else begin
      count     <= (count == LAST) ? '0 : count + CW'(1);
      sec_tick  <= (count == LAST);
      half_tick <= (count == LAST) || (count == HALF);
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm match detection and ring / snooze / stop sequencing with buzzer drive.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [HH_W-1:0] time_hh,
  input  logic [MM_W-1:0] time_mm,
  input  logic [SS_W-1:0] time_ss,
  input  logic [HH_W-1:0] alarm_hh,
  input  logic [MM_W-1:0] alarm_mm,
  input  logic            alarm_en,
  input  logic            snooze_btn,
  input  logic            stop_btn,
  output logic            sec_tick,
  output logic            ringing,
  output logic            buzzer,
  output logic [1:0]      state
);

  localparam int RW = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
  localparam int SW = (SNOOZE_S > 0) ? $clog2(SNOOZE_S + 1) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_S);

  logic half_tick;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .sec_tick (sec_tick),
    .half_tick(half_tick)
  );

  alarm_state_t  state_q, state_n;
  logic [RW-1:0] ring_cnt, ring_cnt_n;
  logic [SW-1:0] snz_cnt, snz_cnt_n;
  logic          buzzer_n;
  logic          time_match, match, match_q, fired, trigger;

  // The fired flag remembers that this matching second already produced a
  // trigger, so toggling alarm_en inside that second cannot ring twice, while
  // a first rise of alarm_en during the second still fires.
  assign time_match = (time_hh == alarm_hh) && (time_mm == alarm_mm) && (time_ss == '0);
  assign match      = alarm_en && time_match;
  assign trigger    = match && !match_q && !fired;

  // Match history registers used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      fired   <= 1'b0;
    end else begin
      match_q <= match;
      if (!time_match) fired <= 1'b0;
      else if (trigger) fired <= 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      buzzer   <= 1'b0;
      ringing  <= 1'b0;
    end else begin
      state_q  <= state_n;
      ring_cnt <= ring_cnt_n;
      snz_cnt  <= snz_cnt_n;
      buzzer   <= buzzer_n;
      ringing  <= (state_n == RING);
    end
  end

  // Next-state logic; buttons outrank the timers, and buzzer defaults to 0 so
  // it drops in the very cycle RING is left.
  always_comb begin
    state_n    = state_q;
    ring_cnt_n = ring_cnt;
    snz_cnt_n  = snz_cnt;
    buzzer_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_n    = RING;
          ring_cnt_n = '0;
          buzzer_n   = 1'b1;
        end
      end
      RING: begin
        if (!alarm_en || stop_btn) begin
          state_n = IDLE;
        end else if (snooze_btn) begin
          state_n   = SNOOZE;
          snz_cnt_n = SNZ_LOAD;
        end else if (sec_tick && (ring_cnt == RING_LAST)) begin
          state_n = IDLE;
        end else begin
          if (sec_tick) ring_cnt_n = ring_cnt + RW'(1);
          buzzer_n = half_tick ? ~buzzer : buzzer;
        end
      end
      SNOOZE: begin
        if (!alarm_en || stop_btn) begin
          state_n = IDLE;
        end else if (sec_tick && (snz_cnt == SW'(1))) begin
          state_n    = RING;
          ring_cnt_n = '0;
          buzzer_n   = 1'b1;
        end else if (sec_tick && (snz_cnt != '0)) begin
          snz_cnt_n = snz_cnt - SW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl against a behavioural model.
module tb_alarm_ctrl;

  localparam int CLK_HZ = 10;
  localparam int SNOOZE_S = 3;
  localparam int RING_TIMEOUT_S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] time_hh, alarm_hh;
  logic [5:0] time_mm, time_ss, alarm_mm;
  logic       alarm_en, snooze_btn, stop_btn;
  logic       sec_tick, ringing, buzzer;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 ringing, 2 snoozing; seconds rung, seconds of snooze
  // left, half-second enables seen since the ring started.
  int m_edges, m_mode, m_ring_secs, m_snooze_left, m_halfs;
  bit m_fired, m_prev_match, m_sec, m_half;

  alarm_ctrl #(
    .CLK_HZ(CLK_HZ), .SNOOZE_S(SNOOZE_S), .RING_TIMEOUT_S(RING_TIMEOUT_S)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .time_hh(time_hh), .time_mm(time_mm), .time_ss(time_ss),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_en(alarm_en),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .sec_tick(sec_tick), .ringing(ringing), .buzzer(buzzer), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] exp_vec();
    logic [1:0] st;
    st = 2'(m_mode);
    return {m_sec, (m_mode == 1), (m_mode == 1) && (m_halfs % 2 == 0), st};
  endfunction

  task automatic model_reset();
    m_edges = 0; m_mode = 0; m_ring_secs = 0; m_snooze_left = 0; m_halfs = 0;
    m_fired = 0; m_prev_match = 0; m_sec = 0; m_half = 0;
  endtask

  task automatic model_step();
    bit tm, mt, trig, tick, half;
    int prev;
    tick = m_sec;
    half = m_half;
    tm = (time_hh == alarm_hh) && (time_mm == alarm_mm) && (time_ss == 0);
    mt = alarm_en && tm;
    trig = mt && !m_prev_match && !m_fired;
    if (!tm) m_fired = 0; else if (trig) m_fired = 1;
    m_prev_match = mt;
    prev = m_mode;
    case (m_mode)
      0: if (trig) begin m_mode = 1; m_ring_secs = 0; m_halfs = 0; end
      1: begin
        if (!alarm_en || stop_btn) m_mode = 0;
        else if (snooze_btn) begin m_mode = 2; m_snooze_left = SNOOZE_S; end
        else if (tick) begin
          m_ring_secs++;
          if (m_ring_secs == RING_TIMEOUT_S) m_mode = 0;
        end
      end
      default: begin
        if (!alarm_en || stop_btn) m_mode = 0;
        else if (tick) begin
          m_snooze_left--;
          if (m_snooze_left == 0) begin m_mode = 1; m_ring_secs = 0; m_halfs = 0; end
        end
      end
    endcase
    if (prev == 1 && m_mode == 1 && half) m_halfs++;
    m_edges++;
    m_sec  = (m_edges % CLK_HZ == 0);
    m_half = (m_edges % (CLK_HZ / 2) == 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    time_hh = 5'(hh); time_mm = 6'(mm); time_ss = 6'(ss);
  endtask

  task automatic arm_alarm();
    set_time(7, 29, 59);
    cycle();
    set_time(7, 30, 0);
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alarm_en = 0; snooze_btn = 0; stop_btn = 0;
    alarm_hh = 5'd7; alarm_mm = 6'd30;
    set_time(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sec_tick, ringing, buzzer, state} !== 5'b0)
      $display("[TB] FAIL reset_outputs: got %b expected %b", {sec_tick, ringing, buzzer, state}, 5'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_prescaler();
    for (int i = 1; i <= 35; i++) begin
      cycle();
      checks++;
      if ({sec_tick, ringing, buzzer, state} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL prescaler_model c%0d: got %b expected %b", i, {sec_tick, ringing, buzzer, state}, exp_vec());
      end
      if (i % 10 == 0) begin
        checks++;
        if (sec_tick !== 1'b1) begin
          errors++;
          $display("[TB] FAIL sec_tick_at_%0d: got %b expected 1", i, sec_tick);
        end
      end
    end
  endtask

  task automatic test_ring_stop();
    alarm_en = 1;
    arm_alarm();
    checks++;
    if (ringing !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ring_start: got %b expected 1", ringing);
    end
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if ({sec_tick, ringing, buzzer, state} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL ring_buzzer c%0d: got %b expected %b", i, {sec_tick, ringing, buzzer, state}, exp_vec());
      end
    end
    stop_btn = 1; cycle(); stop_btn = 0;
    checks++;
    if (state !== 2'd0 || buzzer !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop: got state %0d buzzer %b expected 0 0", state, buzzer);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 4) set_time(7, 30, 1);
      cycle();
      checks++;
      if (ringing !== 1'b0) begin
        errors++;
        $display("[TB] FAIL no_retrigger c%0d: got %b expected 0", i, ringing);
      end
    end
  endtask

  task automatic test_timeout();
    int t, n;
    arm_alarm();
    t = 0; n = 0;
    while (state === 2'd1 && n < 100) begin
      if (sec_tick) t++;
      cycle(); n++;
      checks++;
      if ({sec_tick, ringing, buzzer, state} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL timeout_model c%0d: got %b expected %b", n, {sec_tick, ringing, buzzer, state}, exp_vec());
      end
    end
    checks++;
    if (state !== 2'd0 || buzzer !== 1'b0 || t != RING_TIMEOUT_S) begin
      errors++;
      $display("[TB] FAIL timeout_exit: got state %0d buzzer %b ticks %0d expected 0 0 %0d", state, buzzer, t, RING_TIMEOUT_S);
    end
  endtask

  task automatic test_snooze();
    int t, n;
    arm_alarm();
    cycle(); cycle();
    snooze_btn = 1; cycle(); snooze_btn = 0;
    checks++;
    if (state !== 2'd2 || buzzer !== 1'b0) begin
      errors++;
      $display("[TB] FAIL snooze_enter: got state %0d buzzer %b expected 2 0", state, buzzer);
    end
    t = 0; n = 0;
    while (state === 2'd2 && n < 100) begin
      if (sec_tick) t++;
      if (n == 3) snooze_btn = 1;
      cycle(); n++;
      snooze_btn = 0;
    end
    checks++;
    if (state !== 2'd1 || buzzer !== 1'b1 || t != SNOOZE_S) begin
      errors++;
      $display("[TB] FAIL snooze_expire: got state %0d buzzer %b ticks %0d expected 1 1 %0d", state, buzzer, t, SNOOZE_S);
    end
    t = 0; n = 0;
    while (state === 2'd1 && n < 100) begin
      if (sec_tick) t++;
      cycle(); n++;
    end
    checks++;
    if (state !== 2'd0 || t != RING_TIMEOUT_S) begin
      errors++;
      $display("[TB] FAIL ring_restart: got state %0d ticks %0d expected 0 %0d", state, t, RING_TIMEOUT_S);
    end
  endtask

  task automatic test_stop_snooze();
    arm_alarm();
    stop_btn = 1; snooze_btn = 1; cycle(); stop_btn = 0; snooze_btn = 0;
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL stop_wins: got state %0d expected 0", state);
    end
    arm_alarm();
    snooze_btn = 1; cycle(); snooze_btn = 0;
    alarm_en = 0; cycle();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL snooze_disable: got state %0d expected 0", state);
    end
    alarm_en = 1;
  endtask

  task automatic test_en_glitch();
    arm_alarm();
    alarm_en = 0; cycle();
    alarm_en = 1; cycle(); cycle();
    checks++;
    if (ringing !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_return_no_retrigger: got %b expected 0", ringing);
    end
    set_time(7, 29, 59); alarm_en = 0; cycle();
    set_time(7, 30, 0); cycle();
    alarm_en = 1; cycle();
    checks++;
    if (ringing !== 1'b1) begin
      errors++;
      $display("[TB] FAIL en_rise_triggers: got %b expected 1", ringing);
    end
    stop_btn = 1; cycle(); stop_btn = 0;
  endtask

  task automatic test_async_reset();
    arm_alarm();
    cycle(); cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ringing !== 1'b0 || buzzer !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got ringing %b buzzer %b state %0d expected 0 0 0", ringing, buzzer, state);
    end
    #3;
    rst_n = 1'b1;
    model_reset();
    set_time(12, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cycle();
      checks++;
      if ({sec_tick, ringing, buzzer, state} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL post_reset c%0d: got %b expected %b", i, {sec_tick, ringing, buzzer, state}, exp_vec());
      end
    end
    checks++;
    if (sec_tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_tick: got %b expected 1", sec_tick);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) set_time(7, 29, 59);
        else if (r < 7) set_time(7, 30, 0);
        else if (r == 7) set_time(7, 30, 1);
        else set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      end
      if ($urandom_range(0, 39) == 0) alarm_en = ~alarm_en;
      snooze_btn = ($urandom_range(0, 59) == 0);
      stop_btn = ($urandom_range(0, 149) == 0);
      cycle();
      checks++;
      if ({sec_tick, ringing, buzzer, state} !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random c%0d: got %b expected %b", i, {sec_tick, ringing, buzzer, state}, exp_vec());
      end
    end
    snooze_btn = 0; stop_btn = 0;
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_ring_stop();
    test_timeout();
    test_snooze();
    test_stop_snooze();
    test_en_glitch();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm sequencing controller for the alarm-clock design. Generates the 1 Hz and 2 Hz timing enables from the board clock using a single clock domain, with no derived clocks. Detects when the running time matches the programmed alarm time and runs the ring / snooze / stop state machine. Drives the buzzer and a ringing indicator. Sits between the time-keeping counter, which consumes `sec_tick`, and the button/buzzer I/O.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency; must be even and ≥ 4.
- `SNOOZE_S`, 300, snooze length in seconds (≥ 1).
- `RING_TIMEOUT_S`, 60, maximum ring time in seconds before auto-stop (≥ 1).

Ports:
- `clk`  in  1  system clock; single clock for the whole block.
- `rst_n`  in  1  asynchronous active-low reset.
- `time_hh`  in  5  current hour, 0–23.
- `time_mm`  in  6  current minute, 0–59.
- `time_ss`  in  6  current second, 0–59.
- `alarm_hh`  in  5  alarm hour.
- `alarm_mm`  in  6  alarm minute.
- `alarm_en`  in  1  level; alarm armed.
- `snooze_btn`  in  1  one-cycle pulse, debounced upstream.
- `stop_btn`  in  1  one-cycle pulse, debounced upstream.
- `sec_tick`  out  1  one-cycle pulse, once per CLK_HZ cycles.
- `ringing`  out  1  high while in RING.
- `buzzer`  out  1  2 Hz square wave while ringing; 0 otherwise.
- `state`  out  2  current FSM state, for debug and LEDs.

## Operation
- Prescaler: counter runs 0..CLK_HZ-1 and wraps.
  - `sec_tick` is high when count == CLK_HZ-1.
  - Internal `half_tick` is high when count == CLK_HZ/2-1 or count == CLK_HZ-1.
- Match: `match` = `alarm_en` & (`time_hh`==`alarm_hh`) & (`time_mm`==`alarm_mm`) & (`time_ss`==0).
  - Registered as `match_q`.
  - `trigger` = `match` & !`match_q`, a rising edge, so the alarm fires once per matching minute.
- States: IDLE=0, RING=1, SNOOZE=2. Encoding 3 is illegal and recovers to IDLE.
- IDLE → RING on `trigger`. Clears the ring counter and sets `buzzer`=1.
- RING, in priority order:
  1. !`alarm_en` or `stop_btn` → IDLE.
  2. `snooze_btn` → SNOOZE, loading the snooze counter with SNOOZE_S.
  3. ring counter == RING_TIMEOUT_S-1 on a `sec_tick` → IDLE.
  4. Otherwise, ring counter increments on `sec_tick`.
- SNOOZE, in priority order:
  1. !`alarm_en` or `stop_btn` → IDLE.
  2. snooze counter == 1 on a `sec_tick` → RING, clearing the ring counter and setting `buzzer`=1.
  3. Otherwise, decrement on `sec_tick`.
  - `snooze_btn` is ignored in SNOOZE.
- `trigger` is ignored outside IDLE.
- `buzzer`: toggles on every `half_tick` while in RING. Forced 0 in the same cycle the FSM leaves RING, and held 0 outside RING.
- Counter widths are $clog2 of each parameter range. No counter may wrap except the prescaler.

## Timing
- Reset values: prescaler 0, `sec_tick` 0, state IDLE, `ringing` 0, `buzzer` 0, `match_q` 0, ring/snooze counters 0.
- Reset is asynchronous. Asserting `rst_n` mid-ring drops `ringing` and `buzzer` immediately, without waiting for a clock.
- First `sec_tick` occurs on the CLK_HZ-th rising edge after reset release. Pulses then repeat every CLK_HZ cycles.
- All outputs are registered.
  - `ringing` rises one cycle after the cycle in which `trigger` is high.
  - Button responses take effect one cycle after the pulse.
- Total ring time without a button press is RING_TIMEOUT_S `sec_tick`s, ±1 s phase.
- Snooze length is SNOOZE_S `sec_tick`s after entry, ±1 s phase.
- Simultaneous `stop_btn` and `snooze_btn`: stop wins.
- A button arriving in the same cycle as a timeout or snooze expiry takes priority over the timer.
- `alarm_en` dropping while `match` is high does not retrigger when it returns within the same second. A rise of `alarm_en` during the matching second with ss==0 does trigger.

## Structure
- Package `alarm_pkg` holds:
  - the `alarm_state_t` enum (IDLE/RING/SNOOZE);
  - time field width constants HH_W=5, MM_W=6, SS_W=6.
- Sub-module `tick_gen`, parameterised by CLK_HZ, contains the prescaler. Outputs are `sec_tick` and `half_tick`, both clock enables.
- The FSM, match logic and counters are in `alarm_ctrl`.

## Test plan
Run with CLK_HZ=10, SNOOZE_S=3, RING_TIMEOUT_S=4.
- Reset release, no stimulus → `sec_tick` pulses at cycles 10, 20, 30; `state`=0, `buzzer`=0 throughout.
- Alarm 07:30, `alarm_en`=1, time steps 07:29:59 → 07:30:00 → `ringing`=1 next cycle; `buzzer` toggles every 5 cycles; at 07:30:01 no retrigger after stop.
- RING, no buttons → return to IDLE after 4 `sec_tick`s; `buzzer`=0 on exit.
- RING, `snooze_btn` pulse → SNOOZE, `buzzer`=0; RING re-entered after 3 `sec_tick`s, ring counter restarted.
- RING, `stop_btn` and `snooze_btn` in the same cycle → IDLE. In SNOOZE, `alarm_en`=0 → IDLE next cycle.
- `rst_n` low mid-RING, between clock edges → `ringing`/`buzzer` 0 immediately; after release, `state`=IDLE and prescaler restarts from 0.
